scan_code_gen: RTL and testbench
================================

Name: scan_code_gen

Overview:
- Upstream driver for the 3-to-8 decoder. Produces the 3-bit select code on A/B/C, A = MSB and C = LSB.
- Auto mode: advances on a prescaled tick. Manual mode: advances once per debounced STEP rising edge.
- Masked positions are skipped, so only enabled decoder outputs are ever selected.
- TICK and WRAP strobes let downstream logic latch or align display data.

Parameters:
- DIV_WIDTH, 16: width of the prescaler counter.
- DIV_MAX, 49999: prescaler terminal count. Auto period = DIV_MAX+1 CLK cycles (1 kHz at 50 MHz). Must be ≥1 and < 2^DIV_WIDTH.

Ports:
- CLK, input, 1: system clock; all logic is rising-edge.
- RST, input, 1: asynchronous, active-high reset.
- EN, input, 1: 1 = advancing permitted; 0 = freeze.
- MODE, input, 1: 0 = auto (prescaler), 1 = manual (STEP).
- DIR, input, 1: 0 = count up (0→7), 1 = count down (7→0).
- STEP, input, 1: asynchronous manual step request.
- MASK, input, 8: bit i = 1 means code i is enabled.
- A, output, 1: code bit 2.
- B, output, 1: code bit 1.
- C, output, 1: code bit 0.
- TICK, output, 1: one-cycle strobe; high in the cycle the new code first appears.
- WRAP, output, 1: one-cycle strobe with TICK when the advance crosses the 7/0 boundary.
- NONE, output, 1: combinational, high when MASK == 8'h00.

Behaviour:
- Reset (async assert, sync release on next CLK):
  - code = 3'b000, so A = B = C = 0.
  - TICK = 0, WRAP = 0.
  - Prescaler = 0.
  - STEP synchronizer and edge register = 0.
- Registers: A/B/C, TICK and WRAP are all registered outputs.
- Prescaler:
  - Counts only when EN=1 and MODE=0.
  - Counting 0..DIV_MAX: at DIV_MAX it raises internal adv for one cycle and returns to 0.
  - When EN=0 or MODE=1, it is held at 0.
  - Any change of MODE clears it in that cycle.
- STEP path:
  - Two-flop synchronizer, then rising-edge detect, giving a one-cycle pulse.
  - adv is generated only when EN=1 and MODE=1.
  - Latency: STEP rises → TICK high on the 3rd CLK edge after the first sampling edge.
  - Edges arriving while EN=0 or MODE=0 are discarded, not queued.
  - STEP held high produces exactly one advance.
- Advance, on adv:
  - If MASK == 0: code is held, no TICK, no WRAP.
  - Otherwise the new code is the first enabled position strictly after the current code in direction DIR, searching mod 8 over at most 8 candidates.
  - The current code counts as a candidate only as the 8th, i.e. when it is the sole enabled bit. In that case the code is unchanged but TICK=1 and WRAP=1 (a full cycle).
  - The masked/unmasked state of the current code itself does not matter. A code that becomes masked stays on the outputs until the next adv, then moves on normally.
- WRAP rules:
  - DIR=0: WRAP=1 when new code ≤ old code.
  - DIR=1: WRAP=1 when new code ≥ old code.
- Next-state logic:
  - Search is combinational from the current code, MASK and DIR.
  - MASK and DIR are sampled in the adv cycle.
  - No multicycle search is allowed; the code must update on the same edge that consumes adv.
- Freeze:
  - EN=0 stops all advances and holds the code.
  - Re-asserting EN restarts the prescaler from 0, giving a full period before the next auto advance.
- Mid-operation reset:
  - Code returns to 0 immediately.
  - Any pending synchronizer edge is lost.
  - The first auto advance after release occurs DIV_MAX+1 cycles after release.
- Throughput: at most one advance per cycle. With DIV_MAX=1 auto mode advances every 2 cycles.

Test Plan (bench uses DIV_MAX=3):
- Reset, EN=1, MODE=0, DIR=0, MASK=8'hFF → code 0,1,…,7,0 with TICK every 4 cycles; WRAP=1 only on the 7→0 advance; A/B/C=0,0,1 at the first TICK.
- DIR=1, MASK=8'hFF, start at code 0 → next codes 7,6,5; WRAP=1 on the 0→7 advance.
- MASK=8'b1010_0101, DIR=0 from code 0 → sequence 2,5,7,0 (WRAP on 7→0). Then change MASK to 8'h10 → code 4, then 4 again with TICK=1 and WRAP=1 each period.
- MASK=8'h00 → NONE=1, no TICK for ≥3 periods, code held. Then MASK=8'h01 → next adv yields code 0 with TICK=1.
- MODE=1: STEP held high for 10 cycles → exactly one TICK, 3 cycles after the synchronizer first samples STEP=1. Then EN=0 with a STEP pulse → no advance.
- RST asserted mid-count at code 5 with a STEP edge in the synchronizer → A/B/C=000 immediately, no TICK after release. In auto mode the first TICK is 4 cycles after release.

Source files
------------

// File: rtl/scan_code_gen.sv
// scan_code_gen: drives the 3-bit select code (A=MSB, C=LSB) of a 3-to-8
// decoder. The code advances either on a prescaled tick (auto mode) or once
// per synchronized STEP rising edge (manual mode). Masked positions are
// skipped. TICK marks the cycle a new code appears and WRAP marks a 7/0
// boundary crossing.
module scan_code_gen #(
  parameter int DIV_WIDTH = 16,
  parameter int DIV_MAX   = 49999
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       MODE,
  input  logic       DIR,
  input  logic       STEP,
  input  logic [7:0] MASK,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       TICK,
  output logic       WRAP,
  output logic       NONE
);

  localparam logic [DIV_WIDTH-1:0] DIV_TOP = DIV_WIDTH'(DIV_MAX);

  // Search result layout: {found, wrap, code[2:0]}.
  // The current code is examined only as the 8th candidate, so a sole
  // enabled bit equal to the current code gives a full-cycle advance.
  function automatic logic [4:0] search_next(input logic [2:0] cur,
                                             input logic [7:0] msk,
                                             input logic       down);
    logic [2:0] cand;
    logic [2:0] res;
    logic       found;
    logic       hit;
    logic       wrp;
    found = 1'b0;
    res   = cur;
    for (int i = 1; i <= 8; i++) begin
      cand  = down ? (cur - 3'(i)) : (cur + 3'(i));
      hit   = !found && msk[cand];
      res   = hit ? cand : res;
      found = found | hit;
    end
    wrp = down ? (res >= cur) : (res <= cur);
    return {found, wrp, res};
  endfunction

  logic [DIV_WIDTH-1:0] div_cnt_r;
  logic [DIV_WIDTH-1:0] div_next_s;
  logic                 mode_prev_r;
  logic                 sync1_r;
  logic                 sync2_r;
  logic                 sync3_r;
  logic                 pulse_r;
  logic [2:0]           code_r;
  logic                 tick_r;
  logic                 wrap_r;

  logic                 auto_run_s;
  logic                 adv_auto_s;
  logic                 adv_man_s;
  logic                 adv_s;
  logic [4:0]           srch_s;
  logic [2:0]           code_next_s;
  logic                 tick_next_s;
  logic                 wrap_next_s;

  // Prescaler run condition; a MODE change clears the count in that cycle.
  assign auto_run_s = EN && !MODE && (MODE == mode_prev_r);
  assign adv_man_s  = pulse_r && EN && MODE;
  assign adv_s      = adv_auto_s || adv_man_s;
  assign srch_s     = search_next(code_r, MASK, DIR);

  // Prescaler next count and terminal-count advance request.
  always_comb begin
    div_next_s = '0;
    adv_auto_s = 1'b0;
    if (auto_run_s) begin
      if (div_cnt_r == DIV_TOP) begin
        div_next_s = '0;
        adv_auto_s = 1'b1;
      end else begin
        div_next_s = div_cnt_r + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
      end
    end else begin
      div_next_s = '0;
    end
  end

  // Code update on an advance; an all-zero mask suppresses the advance.
  always_comb begin
    code_next_s = code_r;
    tick_next_s = 1'b0;
    wrap_next_s = 1'b0;
    if (adv_s && srch_s[4]) begin
      code_next_s = srch_s[2:0];
      tick_next_s = 1'b1;
      wrap_next_s = srch_s[3];
    end else begin
      code_next_s = code_r;
    end
  end

  // Prescaler and MODE history registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_cnt_r   <= '0;
      mode_prev_r <= 1'b0;
    end else begin
      div_cnt_r   <= div_next_s;
      mode_prev_r <= MODE;
    end
  end

  // STEP two-flop synchronizer, edge register and registered edge pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      sync1_r <= STEP;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
      pulse_r <= sync2_r && !sync3_r;
    end
  end

  // Registered code and strobes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      code_r <= 3'b000;
      tick_r <= 1'b0;
      wrap_r <= 1'b0;
    end else begin
      code_r <= code_next_s;
      tick_r <= tick_next_s;
      wrap_r <= wrap_next_s;
    end
  end

  assign A    = code_r[2];
  assign B    = code_r[1];
  assign C    = code_r[0];
  assign TICK = tick_r;
  assign WRAP = wrap_r;
  assign NONE = (MASK == 8'h00);

endmodule

// File: tb/tb_scan_code_gen.sv
// Directed bench for scan_code_gen with DIV_MAX=3 (auto period 4 cycles).
module tb_scan_code_gen;

  logic       CLK;
  logic       RST;
  logic       EN;
  logic       MODE;
  logic       DIR;
  logic       STEP;
  logic [7:0] MASK;
  logic       A;
  logic       B;
  logic       C;
  logic       TICK;
  logic       WRAP;
  logic       NONE;

  int total;
  int bad;

  typedef struct {
    logic       dir;
    logic [7:0] mask;
    logic [2:0] exp_code;
    logic       exp_tick;
    logic       exp_wrap;
    logic       exp_none;
  } vec_t;

  vec_t vecs[$];

  scan_code_gen #(.DIV_WIDTH(4), .DIV_MAX(3)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .DIR(DIR), .STEP(STEP),
    .MASK(MASK), .A(A), .B(B), .C(C), .TICK(TICK), .WRAP(WRAP), .NONE(NONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic d, input logic [7:0] m, input logic [2:0] c,
                     input logic t, input logic w);
    vec_t v;
    v.dir = d; v.mask = m; v.exp_code = c; v.exp_tick = t; v.exp_wrap = w;
    v.exp_none = (m == 8'h00);
    vecs.push_back(v);
  endtask

  // One auto period: three quiet cycles, then the advance cycle.
  task automatic run_period(input vec_t v);
    DIR  = v.dir;
    MASK = v.mask;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk("quiet_tick", int'(TICK), 0);
    end
    @(posedge CLK); #1;
    chk("code", int'({A, B, C}), int'(v.exp_code));
    chk("tick", int'(TICK), int'(v.exp_tick));
    chk("wrap", int'(WRAP), int'(v.exp_wrap));
    chk("none", int'(NONE), int'(v.exp_none));
  endtask

  // Raise STEP for 'hold' sampling edges, observe 'cycles' edges in all.
  task automatic do_step(input int hold, input int cycles, input int exp_ticks,
                         input logic [2:0] exp_code, input logic exp_wrap);
    int   ticks;
    int   first;
    logic wseen;
    ticks = 0; first = 0; wseen = 1'b0;
    STEP = 1'b1;
    for (int i = 1; i <= cycles; i++) begin
      @(posedge CLK); #1;
      if (i == hold) STEP = 1'b0;
      if (TICK) begin
        ticks++;
        if (first == 0) begin
          first = i;
          wseen = WRAP;
        end
      end
    end
    chk("step_ticks", ticks, exp_ticks);
    if (exp_ticks > 0) begin
      chk("step_latency", first, 4);
      chk("step_wrap", int'(wseen), int'(exp_wrap));
    end
    chk("step_code", int'({A, B, C}), int'(exp_code));
  endtask

  initial begin
    vec_t v;
    total = 0; bad = 0;
    RST = 1'b1; EN = 1'b1; MODE = 1'b0; DIR = 1'b0; STEP = 1'b0; MASK = 8'hFF;

    for (int i = 1; i <= 7; i++) add(1'b0, 8'hFF, 3'(i), 1'b1, 1'b0);
    add(1'b0, 8'hFF, 3'd0, 1'b1, 1'b1);
    add(1'b1, 8'hFF, 3'd7, 1'b1, 1'b1);
    add(1'b1, 8'hFF, 3'd6, 1'b1, 1'b0);
    add(1'b1, 8'hFF, 3'd5, 1'b1, 1'b0);
    add(1'b0, 8'h01, 3'd0, 1'b1, 1'b1);
    add(1'b0, 8'hA5, 3'd2, 1'b1, 1'b0);
    add(1'b0, 8'hA5, 3'd5, 1'b1, 1'b0);
    add(1'b0, 8'hA5, 3'd7, 1'b1, 1'b0);
    add(1'b0, 8'hA5, 3'd0, 1'b1, 1'b1);
    add(1'b0, 8'h10, 3'd4, 1'b1, 1'b0);
    add(1'b0, 8'h10, 3'd4, 1'b1, 1'b1);
    add(1'b0, 8'h10, 3'd4, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) add(1'b0, 8'h00, 3'd4, 1'b0, 1'b0);
    add(1'b0, 8'h01, 3'd0, 1'b1, 1'b1);
    add(1'b1, 8'h01, 3'd0, 1'b1, 1'b1);
    add(1'b1, 8'h42, 3'd6, 1'b1, 1'b1);
    add(1'b1, 8'h42, 3'd1, 1'b1, 1'b0);
    add(1'b0, 8'h42, 3'd6, 1'b1, 1'b0);

    // Reset state.
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_code", int'({A, B, C}), 0);
    chk("rst_tick", int'(TICK), 0);
    chk("rst_wrap", int'(WRAP), 0);
    chk("rst_none", int'(NONE), 0);
    #1 RST = 1'b0;

    // Auto-mode table.
    foreach (vecs[i]) run_period(vecs[i]);

    // Manual mode: STEP held 10 cycles gives one advance 6 -> 7.
    MODE = 1'b1; DIR = 1'b0; MASK = 8'hFF;
    do_step(10, 14, 1, 3'd7, 1'b0);

    // Frozen: STEP edge discarded.
    EN = 1'b0;
    do_step(3, 10, 0, 3'd7, 1'b0);

    // Re-enabled, sole mask bit 5: 7 -> 5 crosses the boundary.
    EN = 1'b1; MASK = 8'h20;
    do_step(3, 8, 1, 3'd5, 1'b1);

    // Mid-operation reset with a STEP edge in the synchronizer.
    STEP = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b1;
    STEP = 1'b0;
    #1;
    chk("rst_imm_code", int'({A, B, C}), 0);
    chk("rst_imm_tick", int'(TICK), 0);
    MODE = 1'b0; MASK = 8'hFF; DIR = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_hold_code", int'({A, B, C}), 0);
    chk("rst_hold_tick", int'(TICK), 0);
    #1 RST = 1'b0;
    v.dir = 1'b0; v.mask = 8'hFF; v.exp_code = 3'd1; v.exp_tick = 1'b1;
    v.exp_wrap = 1'b0; v.exp_none = 1'b0;
    run_period(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
